// File: rtl/pillar_rf_pkg.sv
// Shared constants and helpers for the pillar integer register file family.
package pillar_rf_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          NREG_DEF     = 32;
  localparam int          SP_IDX_DEF   = 2;
  localparam logic [31:0] SP_RESET_DEF = 32'h0001_2000;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Lowest bit of field k in a packed bus of w-bit fields.
  function automatic int port_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks outstanding destination writes and refuses
// issue on RAW/WAW hazards.
module rf_scoreboard
  import pillar_rf_pkg::*;
#(
  parameter  int NREG   = NREG_DEF,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = idx_w(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic              issue_we_i,
  input  logic [NRD-1:0]    issue_use_i,
  output logic              stall_o,
  input  logic              wb_valid_i,
  input  logic [AW-1:0]     wb_rd_i
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_raw;
  logic            w_waw;
  logic            w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_busy
      logic [AW-1:0] w_addr;
      assign w_addr        = rd_addr_i[port_lo(gi, AW) +: AW];
      // A write-back landing this cycle only hides the pending bit when it is forwarded.
      assign rd_busy_o[gi] = r_busy[w_addr] &&
                             !((BYPASS != 0) && wb_valid_i && (wb_rd_i == w_addr));
    end
  endgenerate

  always_comb begin
    w_raw    = |(issue_use_i & rd_busy_o);
    w_waw    = issue_we_i && (issue_rd_i != '0) && r_busy[issue_rd_i] &&
               !(wb_valid_i && (wb_rd_i == issue_rd_i));
    stall_o  = issue_valid_i && (w_raw || w_waw);
    w_accept = issue_valid_i && !stall_o;

    w_busy_next = r_busy;
    if (wb_valid_i) begin
      w_busy_next[wb_rd_i] = 1'b0;
    end
    // A new producer issued in the same cycle as the old one retires owns the register.
    if (w_accept && issue_we_i) begin
      w_busy_next[issue_rd_i] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// NREG x XLEN register file with NRD combinational read ports, one write-back
// port, optional write-to-read bypass and a busy-bit issue scoreboard.
module regfile_sb
  import pillar_rf_pkg::*;
#(
  parameter  int              XLEN     = XLEN_DEF,
  parameter  int              NREG     = NREG_DEF,
  parameter  int              NRD      = 2,
  parameter  int              BYPASS   = 1,
  parameter  int              SP_IDX   = SP_IDX_DEF,
  parameter  logic [XLEN-1:0] SP_RESET = XLEN'(SP_RESET_DEF),
  localparam int              AW       = idx_w(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                issue_valid_i,
  input  logic [AW-1:0]       issue_rd_i,
  input  logic                issue_we_i,
  input  logic [NRD-1:0]      issue_use_i,
  output logic                stall_o,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wb_valid_i && (wb_rd_i != '0)) begin
      r_regs[wb_rd_i] <= wb_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_byp;
      assign w_addr = rd_addr_i[port_lo(gi, AW) +: AW];
      assign w_byp  = (BYPASS != 0) && wb_valid_i && (wb_rd_i == w_addr);
      assign rd_data_o[port_lo(gi, XLEN) +: XLEN] =
        (w_addr == '0) ? '0 : (w_byp ? wb_data_i : r_regs[w_addr]);
    end
  endgenerate

  rf_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .rd_addr_i     (rd_addr_i),
    .rd_busy_o     (rd_busy_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_we_i    (issue_we_i),
    .issue_use_i   (issue_use_i),
    .stall_o       (stall_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table on BYPASS=1 and BYPASS=0 instances plus
// a randomised NREG=16/NRD=3 instance checked against a reference model.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 32x32, NRD=2 instances.
  logic [9:0]  rd_addr;
  logic        iv, iwe, wv;
  logic [4:0]  ird, wrd;
  logic [1:0]  iuse;
  logic [31:0] wdat;
  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_busy, b_busy;
  logic        a_stall, b_stall;

  // Randomised NREG=16, NRD=3 instance.
  logic [11:0] c_addr;
  logic        c_iv, c_iwe, c_wv;
  logic [3:0]  c_ird, c_wrd;
  logic [2:0]  c_iuse;
  logic [31:0] c_wdat;
  logic [95:0] c_data;
  logic [2:0]  c_busy;
  logic        c_stall;

  regfile_sb #(.BYPASS(1)) u_dut_a (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(a_rd_data),
    .rd_busy_o(a_busy), .issue_valid_i(iv), .issue_rd_i(ird), .issue_we_i(iwe),
    .issue_use_i(iuse), .stall_o(a_stall), .wb_valid_i(wv), .wb_rd_i(wrd),
    .wb_data_i(wdat)
  );

  regfile_sb #(.BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(b_rd_data),
    .rd_busy_o(b_busy), .issue_valid_i(iv), .issue_rd_i(ird), .issue_we_i(iwe),
    .issue_use_i(iuse), .stall_o(b_stall), .wb_valid_i(wv), .wb_rd_i(wrd),
    .wb_data_i(wdat)
  );

  regfile_sb #(.NREG(16), .NRD(3), .BYPASS(1)) u_dut_c (
    .clk(clk), .reset(reset), .rd_addr_i(c_addr), .rd_data_o(c_data),
    .rd_busy_o(c_busy), .issue_valid_i(c_iv), .issue_rd_i(c_ird), .issue_we_i(c_iwe),
    .issue_use_i(c_iuse), .stall_o(c_stall), .wb_valid_i(c_wv), .wb_rd_i(c_wrd),
    .wb_data_i(c_wdat)
  );

  typedef struct packed {
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        iv;
    logic [4:0]  ird;
    logic        iwe;
    logic [1:0]  iuse;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        stall;
  } vec_t;

  typedef struct {
    int          dut;
    string       tag;
    logic [95:0] data;
    logic [2:0]  busy;
    logic        stall;
  } exp_t;

  vec_t vq[$];
  vec_t bq[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(ref vec_t q[$], input logic v_wv, input logic [4:0] v_wrd,
                     input logic [31:0] v_wdat, input logic v_iv, input logic [4:0] v_ird,
                     input logic v_iwe, input logic [1:0] v_iuse, input logic [4:0] v_a0,
                     input logic [4:0] v_a1, input logic [31:0] v_d0, input logic [31:0] v_d1,
                     input logic [1:0] v_busy, input logic v_stall);
    vec_t v;
    v = '{v_wv, v_wrd, v_wdat, v_iv, v_ird, v_iwe, v_iuse, v_a0, v_a1, v_d0, v_d1, v_busy, v_stall};
    q.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    wv = v.wv; wrd = v.wrd; wdat = v.wdat;
    iv = v.iv; ird = v.ird; iwe = v.iwe; iuse = v.iuse;
    rd_addr = {v.a1, v.a0};
  endtask

  task automatic push(input int dut, input string tag, input logic [95:0] d,
                      input logic [2:0] b, input logic s);
    exp_t e;
    e.dut = dut; e.tag = tag; e.data = d; e.busy = b; e.stall = s;
    sb_q.push_back(e);
  endtask

  function automatic void chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", tag, act, exp);
    end
  endfunction

  task automatic sb_check();
    exp_t        e;
    logic [95:0] ad;
    logic [2:0]  ab;
    logic        as;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty actual=0 required=1");
      return;
    end
    e = sb_q.pop_front();
    case (e.dut)
      0:       begin ad = {32'h0, a_rd_data}; ab = {1'b0, a_busy}; as = a_stall; end
      1:       begin ad = {32'h0, b_rd_data}; ab = {1'b0, b_busy}; as = b_stall; end
      default: begin ad = c_data;             ab = c_busy;         as = c_stall; end
    endcase
    $display("txn %s dut%0d data=%h busy=%b stall=%b", e.tag, e.dut, ad, ab, as);
    chk({e.tag, "_data"},  ad,          e.data);
    chk({e.tag, "_busy"},  {93'h0, ab}, {93'h0, e.busy});
    chk({e.tag, "_stall"}, {95'h0, as}, {95'h0, e.stall});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic [95:0] ed;
    logic [2:0]  eb;
    logic        es, raw, waw, byp;
    logic [3:0]  a;

    rd_addr = '0; iv = 0; iwe = 0; wv = 0; ird = '0; wrd = '0; iuse = '0; wdat = '0;
    c_addr = '0; c_iv = 0; c_iwe = 0; c_wv = 0; c_ird = '0; c_wrd = '0; c_iuse = '0; c_wdat = '0;

    // wv wrd wdat | iv ird iwe iuse | a0 a1 | d0 d1 busy{b1,b0} stall
    add(vq, 0, 0, 32'h0,        0, 0, 0, 2'b00, 2, 0, 32'h12000,    32'h0,        2'b00, 0);
    add(vq, 1, 5, 32'hDEADBEEF, 0, 0, 0, 2'b00, 5, 3, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    add(vq, 0, 0, 32'h0,        0, 0, 0, 2'b00, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    add(vq, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 2'b00, 0, 0, 32'h0,        32'h0,        2'b00, 0);
    add(vq, 0, 0, 32'h0,        1, 3, 0, 2'b11, 0, 0, 32'h0,        32'h0,        2'b00, 0);
    add(vq, 0, 0, 32'h0,        1, 7, 1, 2'b00, 7, 2, 32'h0,        32'h12000,    2'b00, 0);
    add(vq, 0, 0, 32'h0,        1, 8, 1, 2'b01, 7, 8, 32'h0,        32'h0,        2'b01, 1);
    add(vq, 1, 7, 32'h55,       1, 8, 1, 2'b01, 7, 8, 32'h55,       32'h0,        2'b00, 0);
    add(vq, 0, 0, 32'h0,        0, 0, 0, 2'b00, 7, 8, 32'h55,       32'h0,        2'b10, 0);
    add(vq, 0, 0, 32'h0,        1, 9, 1, 2'b00, 9, 8, 32'h0,        32'h0,        2'b10, 0);
    add(vq, 0, 0, 32'h0,        1, 9, 1, 2'b00, 9, 8, 32'h0,        32'h0,        2'b11, 1);
    add(vq, 1, 9, 32'h1111,     1, 9, 1, 2'b00, 9, 8, 32'h1111,     32'h0,        2'b10, 0);
    add(vq, 0, 0, 32'h0,        0, 0, 0, 2'b00, 9, 8, 32'h1111,     32'h0,        2'b11, 0);
    add(vq, 0, 0, 32'h0,        1, 0, 0, 2'b01, 9, 8, 32'h1111,     32'h0,        2'b11, 1);
    add(vq, 1, 8, 32'hAB,       1, 0, 0, 2'b10, 8, 9, 32'hAB,       32'h1111,     2'b10, 1);
    add(vq, 1, 9, 32'h2222,     0, 0, 0, 2'b00, 9, 8, 32'h2222,     32'hAB,       2'b00, 0);
    add(vq, 0, 0, 32'h0,        1, 0, 0, 2'b11, 9, 8, 32'h2222,     32'hAB,       2'b00, 0);
    add(vq, 0, 5, 32'h0,        0, 0, 0, 2'b00, 5, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    add(vq, 0, 0, 32'h0,        0, 0, 0, 2'b00, 5, 7, 32'hDEADBEEF, 32'h55,       2'b00, 0);

    // BYPASS=0: the write-back cycle still stalls and reads the old value.
    add(bq, 0, 0, 32'h0,        1, 7, 1, 2'b00, 7, 0, 32'h0,        32'h0,        2'b00, 0);
    add(bq, 0, 0, 32'h0,        1, 0, 0, 2'b01, 7, 0, 32'h0,        32'h0,        2'b01, 1);
    add(bq, 1, 7, 32'h55,       1, 0, 0, 2'b01, 7, 0, 32'h0,        32'h0,        2'b01, 1);
    add(bq, 0, 0, 32'h0,        1, 0, 0, 2'b01, 7, 0, 32'h55,       32'h0,        2'b00, 0);

    // Power-on reset state, observed while reset is still low.
    @(negedge clk);
    rd_addr = {5'd0, 5'd2};
    #1;
    push(0, "por_a", {64'h0, 32'h12000}, 3'b000, 1'b0);
    push(1, "por_b", {64'h0, 32'h12000}, 3'b000, 1'b0);
    sb_check();
    sb_check();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      push(0, $sformatf("vec%0d", i), {32'h0, vq[i].d1, vq[i].d0}, {1'b0, vq[i].busy}, vq[i].stall);
      @(negedge clk);
      sb_check();
    end

    // Leave reg 9 pending, then reset mid-run and sweep every index on port 0.
    @(posedge clk); #1;
    drive('0);
    iv = 1; ird = 5'd9; iwe = 1;
    @(posedge clk); #1;
    reset = 1'b0;
    iv = 1; ird = 5'd0; iwe = 0; iuse = 2'b11;
    for (int idx = 0; idx < 32; idx++) begin
      rd_addr = {5'd9, 5'(idx)};
      #1;
      push(0, $sformatf("rst_a%0d", idx), {64'h0, (idx == 2) ? 32'h12000 : 32'h0}, 3'b000, 1'b0);
      push(1, $sformatf("rst_b%0d", idx), {64'h0, (idx == 2) ? 32'h12000 : 32'h0}, 3'b000, 1'b0);
      sb_check();
      sb_check();
    end
    drive('0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < bq.size(); i++) begin
      @(posedge clk); #1;
      drive(bq[i]);
      push(1, $sformatf("nobyp%0d", i), {32'h0, bq[i].d1, bq[i].d0}, {1'b0, bq[i].busy}, bq[i].stall);
      @(negedge clk);
      sb_check();
    end
    @(posedge clk); #1;
    drive('0);

    // Randomised run; instance C has seen only idle inputs since the last reset.
    for (int i = 0; i < 16; i++) m_regs[i] = (i == 2) ? 32'h12000 : 32'h0;
    m_busy = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      c_wv   = ($urandom_range(0, 2) == 0);
      c_wrd  = 4'($urandom_range(0, 15));
      c_wdat = $urandom;
      c_iv   = ($urandom_range(0, 3) != 0);
      c_ird  = 4'($urandom_range(0, 15));
      c_iwe  = ($urandom_range(0, 3) != 0);
      c_iuse = 3'($urandom_range(0, 7));
      c_addr = 12'($urandom);
      for (int k = 0; k < 3; k++) begin
        a   = c_addr[k*4 +: 4];
        byp = c_wv && (c_wrd == a);
        ed[k*32 +: 32] = (a == 0) ? 32'h0 : (byp ? c_wdat : m_regs[a]);
        eb[k] = m_busy[a] && !byp;
      end
      raw = |(c_iuse & eb);
      waw = c_iwe && (c_ird != 0) && m_busy[c_ird] && !(c_wv && (c_wrd == c_ird));
      es  = c_iv && (raw || waw);
      push(2, $sformatf("rnd%0d", cyc), ed, eb, es);
      @(negedge clk);
      sb_check();
      if (c_wv && (c_wrd != 0)) begin
        m_regs[c_wrd] = c_wdat;
        m_busy[c_wrd] = 1'b0;
      end
      if (c_iv && !es && c_iwe && (c_ird != 0)) m_busy[c_ird] = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
